// File: rtl/ymn_pkg.sv
// Shared constants and configuration checks for the YM-style timing front-ends.
package ymn_pkg;

  // OPLL timing: 4 chip clocks per internal cycle, 18 slots per sample.
  localparam int OPLL_PRESCALE = 4;
  localparam int OPLL_SLOTS    = 18;
  localparam int OPLL_SLOT_W   = 5;

  // OPN timing: 6 chip clocks per internal cycle, 24 slots per sample.
  localparam int OPN_PRESCALE  = 6;
  localparam int OPN_SLOTS     = 24;
  localparam int OPN_SLOT_W    = 5;

  // Every slot index 0..slots-1 must be representable in slot_w bits.
  function automatic bit slots_fit(input int slots, input int slot_w);
    return (slots >= 1) && (slots <= (1 << slot_w));
  endfunction

  // The two phases sit half a period apart, so the prescale must be even.
  function automatic bit prescale_ok(input int prescale);
    return (prescale >= 2) && ((prescale % 2) == 0);
  endfunction

endpackage

// File: rtl/ymn_rst_sync.sv
// Two-flop release synchroniser: asserts asynchronously, releases on clk.
module ymn_rst_sync (
  input  logic clk,
  input  logic rst,
  output logic arm,
  output logic run
);

  logic [1:0] chain;

  // Shift ones in after reset; run goes high on the 2nd edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[0], 1'b1};
  end

  // arm high means run will rise on the coming edge.
  assign arm = chain[0];
  assign run = chain[1];

endmodule

// File: rtl/ymn_phase_gen.sv
// Timing front-end: c1/c2 phase strobes, slot counter, sample sync, stretched ic.
module ymn_phase_gen
  import ymn_pkg::*;
#(
  parameter int PRESCALE = OPLL_PRESCALE,
  parameter int SLOTS    = OPLL_SLOTS,
  parameter int SLOT_W   = OPLL_SLOT_W,
  parameter int IC_HOLD  = 2
) (
  input  logic              MCLK,
  input  logic              RESET,
  input  logic              ce,
  output logic              c1,
  output logic              c2,
  output logic [SLOT_W-1:0] slot,
  output logic              sync,
  output logic              ic
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int FW = $clog2(IC_HOLD + 2);

  localparam logic [PW-1:0]     P_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]     P_HALF = PW'(PRESCALE / 2);
  localparam logic [SLOT_W-1:0] S_LAST = SLOT_W'(SLOTS - 1);
  localparam logic [FW-1:0]     F_LAST = FW'(IC_HOLD - 1);

  generate
    if (!slots_fit(SLOTS, SLOT_W) || !prescale_ok(PRESCALE)) begin : g_bad_cfg
      $error("ymn_phase_gen: bad PRESCALE/SLOTS/SLOT_W combination");
    end
  endgenerate

  logic          arm;
  logic          run;
  logic          tick;
  logic          ph1;
  logic          ph2;
  logic          wrap;
  logic [PW-1:0] pcnt;
  logic [FW-1:0] fcnt;

  ymn_rst_sync u_rst_sync (
    .clk (MCLK),
    .rst (RESET),
    .arm (arm),
    .run (run)
  );

  // ce only counts once the release synchroniser has let the core run.
  assign tick = ce & run;
  assign ph1  = tick && (pcnt == '0);
  assign ph2  = tick && (pcnt == P_HALF);
  assign wrap = ph2 && (slot == S_LAST);

  // Prescaler: position of the current ce tick within one internal cycle.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET)     pcnt <= '0;
    else if (tick) pcnt <= (pcnt == P_LAST) ? '0 : pcnt + 1'b1;
  end

  // Registered strobes: each is high only for the MCLK after its ce tick.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      c1   <= 1'b0;
      c2   <= 1'b0;
      sync <= 1'b0;
    end else begin
      c1   <= ph1;
      c2   <= ph2;
      sync <= wrap;
    end
  end

  // Slot advances with c2 so the new index is visible alongside the strobe.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET)    slot <= '0;
    else if (ph2) slot <= wrap ? '0 : slot + 1'b1;
  end

  // ic holds for IC_HOLD whole frames, dropping on the closing sync edge.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      ic   <= 1'b1;
      fcnt <= '0;
    end else if (IC_HOLD == 0) begin
      if (arm) ic <= 1'b0;
    end else if (wrap && ic) begin
      fcnt <= fcnt + 1'b1;
      if (fcnt == F_LAST) ic <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ymn_phase_gen.sv
// Self-checking bench: OPLL-style instance (4/18, hold 2) and a fast one (2/5, hold 0).
module tb_ymn_phase_gen;

  localparam int P0 = 4, S0 = 18, H0 = 2;
  localparam int P1 = 2, S1 = 5,  H1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, ce_a, c1_a, c2_a, sync_a, ic_a;
  logic [4:0] slot_a;
  logic       rst_b, ce_b, c1_b, c2_b, sync_b, ic_b;
  logic [4:0] slot_b;

  ymn_phase_gen #(.PRESCALE(P0), .SLOTS(S0), .SLOT_W(5), .IC_HOLD(H0)) dut_a (
    .MCLK(clk), .RESET(rst_a), .ce(ce_a), .c1(c1_a), .c2(c2_a),
    .slot(slot_a), .sync(sync_a), .ic(ic_a)
  );

  ymn_phase_gen #(.PRESCALE(P1), .SLOTS(S1), .SLOT_W(5), .IC_HOLD(H1)) dut_b (
    .MCLK(clk), .RESET(rst_b), .ce(ce_b), .c1(c1_b), .c2(c2_b),
    .slot(slot_b), .sync(sync_b), .ic(ic_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: count accepted ce ticks; everything follows from the tick index.
  int PP[2] = '{P0, P1};
  int SS[2] = '{S0, S1};
  int HH[2] = '{H0, H1};
  int rel[2];
  int k[2];
  bit m_c1[2];
  bit m_c2[2];
  bit en[2] = '{1'b0, 1'b0};

  function automatic int m_cnt(input int d);
    return (k[d] + PP[d] / 2 - 1) / PP[d];
  endfunction
  function automatic int m_slot(input int d);
    return m_cnt(d) % SS[d];
  endfunction
  function automatic bit m_sync(input int d);
    return m_c2[d] && (m_slot(d) == 0);
  endfunction
  function automatic bit m_ic(input int d);
    return (rel[d] < 2) || ((m_cnt(d) / SS[d]) < HH[d]);
  endfunction

  task automatic mstep(input int d, input bit r, input bit c);
    bit acc;
    if (r) begin
      rel[d] = 0; k[d] = 0; m_c1[d] = 1'b0; m_c2[d] = 1'b0;
    end else begin
      acc     = c && (rel[d] >= 2);
      m_c1[d] = acc && (k[d] % PP[d] == 0);
      m_c2[d] = acc && (k[d] % PP[d] == PP[d] / 2);
      if (acc) k[d]++;
      if (rel[d] < 2) rel[d]++;
    end
  endtask

  always @(posedge clk or posedge rst_a) mstep(0, rst_a, ce_a);
  always @(posedge clk or posedge rst_b) mstep(1, rst_b, ce_b);

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (en[0]) begin
      chk("a_c1",   32'(c1_a),   32'(m_c1[0]));
      chk("a_c2",   32'(c2_a),   32'(m_c2[0]));
      chk("a_slot", 32'(slot_a), 32'(m_slot(0)));
      chk("a_sync", 32'(sync_a), 32'(m_sync(0)));
      chk("a_ic",   32'(ic_a),   32'(m_ic(0)));
      chk("a_ovl",  32'(c1_a & c2_a), 32'd0);
    end
    if (en[1]) begin
      chk("b_c1",   32'(c1_b),   32'(m_c1[1]));
      chk("b_c2",   32'(c2_b),   32'(m_c2[1]));
      chk("b_slot", 32'(slot_b), 32'(m_slot(1)));
      chk("b_sync", 32'(sync_b), 32'(m_sync(1)));
      chk("b_ic",   32'(ic_b),   32'(m_ic(1)));
      chk("b_ovl",  32'(c1_b & c2_b), 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Hand-computed start-up sequence for dut_a, just after release with ce=1.
  task automatic s1_lit();
    tick(1); chk("s1_e1_c1", 32'(c1_a), 0); chk("s1_e1_ic", 32'(ic_a), 1);
    tick(1); chk("s1_e2_c1", 32'(c1_a), 0); chk("s1_e2_ic", 32'(ic_a), 1);
    tick(1); chk("s1_e3_c1", 32'(c1_a), 1); chk("s1_e3_c2", 32'(c2_a), 0);
             chk("s1_e3_slot", 32'(slot_a), 0);
    tick(1); chk("s1_e4_c1", 32'(c1_a), 0); chk("s1_e4_c2", 32'(c2_a), 0);
    tick(1); chk("s1_e5_c2", 32'(c2_a), 1); chk("s1_e5_slot", 32'(slot_a), 1);
             chk("s1_e5_c1", 32'(c1_a), 0);
    tick(1); chk("s1_e6_c2", 32'(c2_a), 0);
    tick(1); chk("s1_e7_c1", 32'(c1_a), 1);
  endtask

  initial begin
    bit hit;
    rst_a = 1'b1; rst_b = 1'b1; ce_a = 1'b0; ce_b = 1'b0;
    #17;
    en[0] = 1'b1; en[1] = 1'b1;
    chk("rst_a_ic",   32'(ic_a),   1);
    chk("rst_a_slot", 32'(slot_a), 0);
    chk("rst_a_c1",   32'(c1_a),   0);

    // Scenarios 1-3: ce every MCLK, frame and ic timing.
    tick(1);
    rst_a = 1'b0; ce_a = 1'b1;
    s1_lit();
    tick(66);  chk("sync1", 32'(sync_a), 1); chk("sync1_slot", 32'(slot_a), 0);
               chk("sync1_ic", 32'(ic_a), 1);
    tick(1);   chk("sync1_end", 32'(sync_a), 0);
    tick(70);  chk("pre_sync2_ic", 32'(ic_a), 1); chk("pre_sync2", 32'(sync_a), 0);
    tick(1);   chk("sync2", 32'(sync_a), 1); chk("sync2_ic", 32'(ic_a), 0);
    tick(72);  chk("sync3", 32'(sync_a), 1); chk("sync3_ic", 32'(ic_a), 0);

    // Scenario 4: ce every 3rd MCLK, then scenario 5: async reset at slot 9.
    rst_a = 1'b1; ce_a = 1'b0;
    tick(2);
    rst_a = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 2000 && !hit; cyc++) begin
      ce_a = (cyc % 3 == 0);
      tick(1);
      if (m_slot(0) == 9) hit = 1'b1;
    end
    chk("slot9_reached", 32'(hit), 1);
    chk("pre_rst_slot", 32'(slot_a), 9);
    #1 rst_a = 1'b1;
    #1;
    chk("async_c1",   32'(c1_a),   0);
    chk("async_c2",   32'(c2_a),   0);
    chk("async_sync", 32'(sync_a), 0);
    chk("async_slot", 32'(slot_a), 0);
    chk("async_ic",   32'(ic_a),   1);
    ce_a = 1'b0;
    tick(2);
    rst_a = 1'b0; ce_a = 1'b1;
    s1_lit();
    tick(20);

    // Scenario 6: PRESCALE=2, IC_HOLD=0, ce every MCLK.
    rst_b = 1'b0; ce_b = 1'b1;
    tick(1); chk("b_e1_ic", 32'(ic_b), 1); chk("b_e1_c1", 32'(c1_b), 0);
    tick(1); chk("b_e2_ic", 32'(ic_b), 0); chk("b_e2_c1", 32'(c1_b), 0);
    tick(1); chk("b_e3_c1", 32'(c1_b), 1); chk("b_e3_c2", 32'(c2_b), 0);
    tick(1); chk("b_e4_c2", 32'(c2_b), 1); chk("b_e4_slot", 32'(slot_b), 1);
             chk("b_e4_c1", 32'(c1_b), 0);
    tick(1); chk("b_e5_c1", 32'(c1_b), 1);
    tick(7); chk("b_sync", 32'(sync_b), 1); chk("b_sync_slot", 32'(slot_b), 0);
    tick(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
